tdp_ram_be_clr: RTL

Parametrised true-dual-port RAM. It is the next-generation storage block for the CartPole datapath (state/replay buffers).
- Adds per-lane byte write enables.
- Adds a selectable same-port read-during-write mode and an optional output register stage.
- Defines deterministic handling of port collisions.
- Replaces the one-cycle whole-array reset clear with a synthesizable sequential clear engine. The engine runs after reset or on request.

---
 rtl/tdp_ram_be_clr_pkg.sv | 45 ++++
 rtl/tdp_ram_be_clr_if.sv | 44 ++++
 rtl/tdp_ram_be_clr_ram_clr_seq.sv | 71 +++++++
 rtl/tdp_ram_be_clr.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/tdp_ram_be_clr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tdp_ram_pkg
//  Purpose  : Shared constants and helpers for the byte-enabled true-dual-port
//             RAM with sequential clear: read-during-write mode codes, the
//             clear-sequencer state encoding and the lane-merge function.
//  Revision : 1.0 - initial release
// ============================================================================
package tdp_ram_pkg;

    // Same-port read-during-write behaviour
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Clear sequencer states
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Widest word / lane count the merge helper handles; callers zero-extend
    // their operands and truncate the result back to their own width.
    localparam int LM_MAX_WIDTH = 256;
    localparam int LM_MAX_LANES = 256;

    // Returns old_word with every lane whose enable bit is set replaced by
    // the matching lane of new_word.
    function automatic logic [LM_MAX_WIDTH-1:0] lane_merge(
        input logic [LM_MAX_WIDTH-1:0] old_word,
        input logic [LM_MAX_WIDTH-1:0] new_word,
        input logic [LM_MAX_LANES-1:0] be,
        input int unsigned             lane_width
    );
        logic [LM_MAX_WIDTH-1:0] lane_ones;
        logic [LM_MAX_WIDTH-1:0] mask;
        lane_ones = (LM_MAX_WIDTH'(1) << lane_width) - LM_MAX_WIDTH'(1);
        mask      = '0;
        for (int k = 0; k < LM_MAX_LANES; k++) begin
            if (be[k]) begin
                mask = mask | (lane_ones << (unsigned'(k) * lane_width));
            end
        end
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdp_ram_be_clr_if.sv
`default_nettype none
// ============================================================================
//  Module   : tdp_ram_be_clr_if
//  Purpose  : Bus bundle of the dual-port RAM. master = client side,
//             slave = RAM side.
//  Signals  : i_clr/o_ready      clear request / array available
//             i_wrN (active-low), i_beN, i_addrN, i_dataN, o_dataN  port N
//             o_collision        same-address overlapping-lane write pulse
//  Revision : 1.0 - initial release
// ============================================================================
interface tdp_ram_be_clr_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 48,
    parameter int LANE_WIDTH = 8
);
    localparam int NLANES = DATA_WIDTH / LANE_WIDTH;

    logic                  i_clr;
    logic                  o_ready;
    logic                  i_wr1;
    logic [NLANES-1:0]     i_be1;
    logic [ADDR_WIDTH-1:0] i_addr1;
    logic [DATA_WIDTH-1:0] i_data1;
    logic [DATA_WIDTH-1:0] o_data1;
    logic                  i_wr2;
    logic [NLANES-1:0]     i_be2;
    logic [ADDR_WIDTH-1:0] i_addr2;
    logic [DATA_WIDTH-1:0] i_data2;
    logic [DATA_WIDTH-1:0] o_data2;
    logic                  o_collision;

    modport master (
        output i_clr, i_wr1, i_be1, i_addr1, i_data1,
               i_wr2, i_be2, i_addr2, i_data2,
        input  o_ready, o_data1, o_data2, o_collision
    );

    modport slave (
        input  i_clr, i_wr1, i_be1, i_addr1, i_data1,
               i_wr2, i_be2, i_addr2, i_data2,
        output o_ready, o_data1, o_data2, o_collision
    );
endinterface
`default_nettype wire

// File: rtl/tdp_ram_be_clr_ram_clr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ram_clr_seq
//  Purpose  : CLEAR/RUN sequencer. After reset, or on i_clr while running,
//             it walks every address once, requesting a zero write of the
//             whole word on port 1, then hands the array back.
//  Ports    : i_clk, i_rstn (sync, active-low), i_clr (clear request),
//             o_ready (1 in RUN), o_clr_we (zero-write override active),
//             o_clr_addr (address being cleared)
//  Revision : 1.0 - initial release
// ============================================================================
module ram_clr_seq
    import tdp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rstn,
    input  wire logic                  i_clr,
    output logic                       o_ready,
    output logic                       o_clr_we,
    output logic [ADDR_WIDTH-1:0]      o_clr_addr
);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; i_clr is only looked at in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        o_ready    = (state_q == ST_RUN);
        o_clr_we   = (state_q == ST_CLEAR);
        o_clr_addr = cnt_q;
    end
endmodule
`default_nettype wire

// File: rtl/tdp_ram_be_clr.sv
`default_nettype none
// ============================================================================
//  Module   : tdp_ram_be_clr
//  Purpose  : True-dual-port RAM with per-lane write enables, selectable
//             same-port read-during-write, optional output register and a
//             sequential whole-array clear.
//  Ports    : i_clk, i_rstn (sync, active-low), bus (slave modport of
//             tdp_ram_be_clr_if: clear handshake, two read/write ports,
//             collision pulse)
//  Revision : 1.0 - initial release
// ============================================================================
module tdp_ram_be_clr
    import tdp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 48,
    parameter int LANE_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  wire logic         i_clk,
    input  wire logic         i_rstn,
    tdp_ram_be_clr_if.slave   bus
);
    localparam int NLANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    logic                  w_ready;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;

    ram_clr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr_seq (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_clr      (bus.i_clr),
        .o_ready    (w_ready),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Port 1 is taken over by the clear engine; port 2 writes are blocked
    logic                  w_we1, w_we2;
    logic [NLANES-1:0]     w_be1;
    logic [ADDR_WIDTH-1:0] w_addr1;
    logic [DATA_WIDTH-1:0] w_wdata1;

    always_comb begin
        if (w_clr_we) begin
            w_we1    = 1'b1;
            w_be1    = '1;
            w_addr1  = w_clr_addr;
            w_wdata1 = '0;
        end else begin
            w_we1    = ~bus.i_wr1;
            w_be1    = bus.i_be1;
            w_addr1  = bus.i_addr1;
            w_wdata1 = bus.i_data1;
        end
        w_we2 = w_ready & ~bus.i_wr2;
    end

    // Storage is split per lane so each lane has its own enable. Port 1 is
    // written last so it wins on lanes both ports hit at the same address.
    logic [DATA_WIDTH-1:0] w_old1, w_old2;

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        logic [LANE_WIDTH-1:0] mem_q [DEPTH];

        always_ff @(posedge i_clk) begin
            if (w_we2 && bus.i_be2[k]) begin
                mem_q[bus.i_addr2] <= bus.i_data2[k*LANE_WIDTH +: LANE_WIDTH];
            end
            if (w_we1 && w_be1[k]) begin
                mem_q[w_addr1] <= w_wdata1[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end

        assign w_old1[k*LANE_WIDTH +: LANE_WIDTH] = mem_q[w_addr1];
        assign w_old2[k*LANE_WIDTH +: LANE_WIDTH] = mem_q[bus.i_addr2];
    end

    // Write-first only folds in the port's own write; the other port's
    // write to the same address is never visible this cycle.
    logic [DATA_WIDTH-1:0] w_rd1, w_rd2;

    always_comb begin
        w_rd1 = w_old1;
        w_rd2 = w_old2;
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            if (w_we1) begin
                w_rd1 = DATA_WIDTH'(lane_merge(LM_MAX_WIDTH'(w_old1), LM_MAX_WIDTH'(w_wdata1),
                                               LM_MAX_LANES'(w_be1), unsigned'(LANE_WIDTH)));
            end
            if (w_we2) begin
                w_rd2 = DATA_WIDTH'(lane_merge(LM_MAX_WIDTH'(w_old2), LM_MAX_WIDTH'(bus.i_data2),
                                               LM_MAX_LANES'(bus.i_be2), unsigned'(LANE_WIDTH)));
            end
        end
    end

    logic w_coll;
    assign w_coll = w_ready & w_we1 & w_we2 & (w_addr1 == bus.i_addr2) & (|(w_be1 & bus.i_be2));

    logic [DATA_WIDTH-1:0] rd1_q, rd2_q;
    logic                  coll_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rd1_q  <= '0;
            rd2_q  <= '0;
            coll_q <= 1'b0;
        end else begin
            coll_q <= w_coll;
            if (!w_ready) begin
                rd1_q <= '0;
                rd2_q <= '0;
            end else begin
                rd1_q <= w_rd1;
                rd2_q <= w_rd2;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out1_q, out2_q;

        always_ff @(posedge i_clk) begin
            if (!i_rstn || !w_ready) begin
                out1_q <= '0;
                out2_q <= '0;
            end else begin
                out1_q <= rd1_q;
                out2_q <= rd2_q;
            end
        end

        assign bus.o_data1 = out1_q;
        assign bus.o_data2 = out2_q;
    end else begin : g_out_direct
        assign bus.o_data1 = rd1_q;
        assign bus.o_data2 = rd2_q;
    end

    assign bus.o_ready     = w_ready;
    assign bus.o_collision = coll_q;
endmodule
`default_nettype wire
